arm_id_stage_pipe: RTL
======================

Name: arm_id_stage_pipe

Overview:
- Parametrised ARM decode stage: condition check, control decode and register-file read addressing, all ending in a registered ID/EX pipeline register.
- Adds hazard detection with stall, branch flush and status-flag hazard handling.
- Sits between the IF/ID register and the EX stage; the register file is external with combinational reads.

Parameters:
DATA_W, 32, datapath and PC width
NUM_REGS, 16, architectural register count; REG_AW = $clog2(NUM_REGS)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous, active-low reset
if_valid  in  1  IF/ID holds a valid instruction
if_pc  in  DATA_W  PC+4 of the instruction
if_instr  in  32  instruction word
status  in  4  {N,Z,C,V} = status[3:0]
flush  in  1  branch taken in EX; squash ID
ex_wb_en  in  1  EX-stage instruction writes a register
ex_dest  in  REG_AW  EX destination register
ex_mem_read  in  1  EX-stage instruction is LDR
ex_s_en  in  1  EX-stage instruction updates status
mem_wb_en  in  1  MEM-stage instruction writes a register
mem_dest  in  REG_AW  MEM destination register
rf_src1  out  REG_AW  Rn = instr[19:16] (combinational)
rf_src2  out  REG_AW  STR: instr[15:12], otherwise instr[3:0] (combinational)
rf_val1, rf_val2  in  DATA_W  register-file read data
stall  out  1  freeze PC and IF/ID (combinational)
id_valid, id_wb_en, id_mem_read, id_mem_write, id_b, id_s, id_imm  out  1 each  registered
id_exe_cmd  out  4  registered ALU command
id_pc, id_val_rn, id_val_rm  out  DATA_W  registered
id_shift_op  out  12  registered instr[11:0]
id_simm24  out  24  registered instr[23:0]
id_dest, id_src1, id_src2  out  REG_AW  registered

Behaviour:
- Reset (rst_n=0 at a clock edge): every registered output is 0. stall is combinational and reads 0 while if_valid=0.
- Condition check on instr[31:28] against status:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V)
  - AL 1; 1111 is treated as 0
- Mode instr[27:26]=00 (data processing): id_exe_cmd from opcode instr[24:21]:
  - MOV 1101→0001; MVN 1111→1001; ADD 0100→0010; ADC 0101→0011
  - SUB 0010→0100; SBC 0110→0101; AND 0000→0110; ORR 1100→0111; EOR 0001→1000
  - CMP 1010→0100 and TST 1000→0110, both with wb_en=0
  - Any other opcode is a bubble.
  - wb_en=1 except CMP/TST; s = instr[20].
- Mode 01 (memory): cmd 0010. instr[20]=1 → LDR (mem_read, wb_en). instr[20]=0 → STR (mem_write).
- Mode 10 (branch): b=1, cmd 0000. Mode 11 is a bubble.
- Source usage:
  - src1 is used unless the instruction is MOV, MVN or branch.
  - src2 is used when (mode 00 and id_imm=0) or STR.
  - id_imm = instr[25]; id_dest = instr[15:12].
- Hazard, default build: if_valid and a used src matches ex_dest with ex_wb_en, or matches mem_dest with mem_wb_en.
- Status hazard: if_valid, cond≠AL and ex_s_en=1 → hazard, independent of register hazard.
- stall = hazard & !flush.
- Each clock, in priority order:
  1. rst_n=0 → clear all registered outputs.
  2. flush → load a bubble (id_valid and all controls 0).
  3. stall → load a bubble; IF/ID holds, so the same instruction re-decodes next cycle.
  4. !if_valid or condition fail → load a bubble.
  5. Otherwise latch the decoded instruction with id_valid=1.
- Bubble rule: datapath fields may take any value, but id_valid, wb_en, mem_read, mem_write, b and s must all be 0.
- Latency: 1 cycle from IF/ID to ID/EX.
- Hazard on register 0 is not exempt; every register compares.

Optional Feature:
- ID_FORWARDING_EN defined: register hazard is load-use only (ex_mem_read & ex_wb_en & ex_dest matches a used src); the MEM-stage compare is removed. Status hazard is unchanged. id_src1/id_src2 feed the forwarding unit.
- ID_FORWARDING_EN undefined: full EX/MEM register compare as in Behaviour.

Decomposition:
- Package arm_pkg: mode, opcode and exe_cmd localparams; condition-code constants; a struct for the ID/EX control bundle.
- One sub-module, arm_cond_check: combinational, inputs cond[3:0] and status[3:0], output cond_ok.

Test Plan:
- ADD R1,R2,R3 (0xE0821003), status 0, no hazards → next cycle id_valid=1, id_exe_cmd=0010, id_wb_en=1, id_dest=1, rf_src1=2, rf_src2=3.
- SUBEQ (cond 0000) with status Z=0 → bubble: id_valid=0, id_wb_en=0. The same instruction with Z=1 → id_exe_cmd=0100.
- ADD R4,R1,R5 with ex_wb_en=1, ex_dest=1 → stall=1 and a bubble is loaded. The following cycle, with ex_wb_en=0, the instruction issues.
- Stall and flush in the same cycle → stall=0, bubble loaded, id_valid=0.
- CMP R1,R2 after ex_s_en=1 with cond NE → 1-cycle stall, then id_wb_en=0, id_s=1, id_exe_cmd=0100.
- Under ID_FORWARDING_EN: ex_dest=1, ex_wb_en=1, ex_mem_read=0 → no stall. With ex_mem_read=1 → stall=1. Reset asserted mid-stall → all outputs 0 next edge.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared definitions for the ARM decode stage: instruction field encodings,
// ALU command encodings, condition codes and the ID/EX control bundle.
package arm_pkg;

    // Instruction class, instr[27:26]
    localparam logic [1:0] MODE_DP  = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;

    // Data-processing opcodes, instr[24:21]
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    // ALU commands driven to the EX stage
    localparam logic [3:0] CMD_NONE = 4'b0000;
    localparam logic [3:0] CMD_MOV  = 4'b0001;
    localparam logic [3:0] CMD_ADD  = 4'b0010;
    localparam logic [3:0] CMD_ADC  = 4'b0011;
    localparam logic [3:0] CMD_SUB  = 4'b0100;
    localparam logic [3:0] CMD_SBC  = 4'b0101;
    localparam logic [3:0] CMD_AND  = 4'b0110;
    localparam logic [3:0] CMD_ORR  = 4'b0111;
    localparam logic [3:0] CMD_EOR  = 4'b1000;
    localparam logic [3:0] CMD_MVN  = 4'b1001;

    // Condition codes, instr[31:28]
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Control bundle carried in the ID/EX register
    typedef struct packed {
        logic       valid;
        logic       wb_en;
        logic       mem_read;
        logic       mem_write;
        logic       b;
        logic       s;
        logic       imm;
        logic [3:0] exe_cmd;
    } id_ctrl_t;

    localparam id_ctrl_t ID_CTRL_BUBBLE = '{
        valid:     1'b0,
        wb_en:     1'b0,
        mem_read:  1'b0,
        mem_write: 1'b0,
        b:         1'b0,
        s:         1'b0,
        imm:       1'b0,
        exe_cmd:   4'b0000
    };

endpackage

// File: rtl/arm_cond_check.sv
// Combinational ARM condition evaluation of cond[3:0] against {N,Z,C,V}.
// The 1111 encoding never passes.
module arm_cond_check
    import arm_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] status,
    output logic       cond_ok
);

    logic n_s;
    logic z_s;
    logic c_s;
    logic v_s;

    assign n_s = status[3];
    assign z_s = status[2];
    assign c_s = status[1];
    assign v_s = status[0];

    // Evaluate the condition field against the current flags
    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            COND_EQ: cond_ok = z_s;
            COND_NE: cond_ok = ~z_s;
            COND_CS: cond_ok = c_s;
            COND_CC: cond_ok = ~c_s;
            COND_MI: cond_ok = n_s;
            COND_PL: cond_ok = ~n_s;
            COND_VS: cond_ok = v_s;
            COND_VC: cond_ok = ~v_s;
            COND_HI: cond_ok = c_s & ~z_s;
            COND_LS: cond_ok = ~c_s | z_s;
            COND_GE: cond_ok = (n_s == v_s);
            COND_LT: cond_ok = (n_s != v_s);
            COND_GT: cond_ok = ~z_s & (n_s == v_s);
            COND_LE: cond_ok = z_s | (n_s != v_s);
            COND_AL: cond_ok = 1'b1;
            COND_NV: cond_ok = 1'b0;
            default: cond_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/arm_id_stage_pipe.sv
// ARM instruction decode stage with hazard detection and ID/EX register.
// Configuration macro: ID_FORWARDING_EN -- when defined, only load-use
// hazards against the EX stage stall (a forwarding unit covers the rest);
// when undefined, any pending EX/MEM register write to a used source stalls.
module arm_id_stage_pipe
    import arm_pkg::*;
#(
    parameter  int DATA_W   = 32,
    parameter  int NUM_REGS = 16,
    localparam int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid,
    input  logic [DATA_W-1:0] if_pc,
    input  logic [31:0]       if_instr,
    input  logic [3:0]        status,
    input  logic              flush,
    input  logic              ex_wb_en,
    input  logic [REG_AW-1:0] ex_dest,
    input  logic              ex_mem_read,
    input  logic              ex_s_en,
    input  logic              mem_wb_en,
    input  logic [REG_AW-1:0] mem_dest,
    output logic [REG_AW-1:0] rf_src1,
    output logic [REG_AW-1:0] rf_src2,
    input  logic [DATA_W-1:0] rf_val1,
    input  logic [DATA_W-1:0] rf_val2,
    output logic              stall,
    output logic              id_valid,
    output logic              id_wb_en,
    output logic              id_mem_read,
    output logic              id_mem_write,
    output logic              id_b,
    output logic              id_s,
    output logic              id_imm,
    output logic [3:0]        id_exe_cmd,
    output logic [DATA_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_val_rn,
    output logic [DATA_W-1:0] id_val_rm,
    output logic [11:0]       id_shift_op,
    output logic [23:0]       id_simm24,
    output logic [REG_AW-1:0] id_dest,
    output logic [REG_AW-1:0] id_src1,
    output logic [REG_AW-1:0] id_src2
);

    logic [1:0]        mode_s;
    logic [3:0]        opcode_s;
    logic              is_str_s;
    logic              legal_s;
    logic              use_src1_s;
    logic              use_src2_s;
    logic              cond_ok_s;
    logic              reg_hz_s;
    logic              stat_hz_s;
    logic              hazard_s;
    logic              issue_s;
    logic              unused_fwd_s;
    id_ctrl_t          ctrl_s;
    logic [REG_AW-1:0] src1_s;
    logic [REG_AW-1:0] src2_s;
    logic [REG_AW-1:0] dest_s;

    id_ctrl_t          ctrl_r;
    logic [DATA_W-1:0] pc_r;
    logic [DATA_W-1:0] val_rn_r;
    logic [DATA_W-1:0] val_rm_r;
    logic [11:0]       shift_op_r;
    logic [23:0]       simm24_r;
    logic [REG_AW-1:0] dest_r;
    logic [REG_AW-1:0] src1_r;
    logic [REG_AW-1:0] src2_r;

    assign mode_s   = if_instr[27:26];
    assign opcode_s = if_instr[24:21];
    assign is_str_s = (mode_s == MODE_MEM) & ~if_instr[20];

    // Register-file read addresses; stores read Rd as the data operand
    assign src1_s  = REG_AW'(if_instr[19:16]);
    assign src2_s  = is_str_s ? REG_AW'(if_instr[15:12]) : REG_AW'(if_instr[3:0]);
    assign dest_s  = REG_AW'(if_instr[15:12]);
    assign rf_src1 = src1_s;
    assign rf_src2 = src2_s;

    arm_cond_check u_cond_check (
        .cond    (if_instr[31:28]),
        .status  (status),
        .cond_ok (cond_ok_s)
    );

    // Decode instruction class and opcode into the control bundle and source usage
    always_comb begin
        ctrl_s      = ID_CTRL_BUBBLE;
        ctrl_s.imm  = if_instr[25];
        legal_s     = 1'b0;
        use_src1_s  = 1'b1;
        use_src2_s  = 1'b0;
        case (mode_s)
            MODE_DP: begin
                legal_s      = 1'b1;
                use_src2_s   = ~if_instr[25];
                ctrl_s.wb_en = 1'b1;
                ctrl_s.s     = if_instr[20];
                case (opcode_s)
                    OP_MOV: begin
                        ctrl_s.exe_cmd = CMD_MOV;
                        use_src1_s     = 1'b0;
                    end
                    OP_MVN: begin
                        ctrl_s.exe_cmd = CMD_MVN;
                        use_src1_s     = 1'b0;
                    end
                    OP_ADD: ctrl_s.exe_cmd = CMD_ADD;
                    OP_ADC: ctrl_s.exe_cmd = CMD_ADC;
                    OP_SUB: ctrl_s.exe_cmd = CMD_SUB;
                    OP_SBC: ctrl_s.exe_cmd = CMD_SBC;
                    OP_AND: ctrl_s.exe_cmd = CMD_AND;
                    OP_ORR: ctrl_s.exe_cmd = CMD_ORR;
                    OP_EOR: ctrl_s.exe_cmd = CMD_EOR;
                    OP_CMP: begin
                        ctrl_s.exe_cmd = CMD_SUB;
                        ctrl_s.wb_en   = 1'b0;
                    end
                    OP_TST: begin
                        ctrl_s.exe_cmd = CMD_AND;
                        ctrl_s.wb_en   = 1'b0;
                    end
                    default: begin
                        legal_s        = 1'b0;
                        ctrl_s.exe_cmd = CMD_NONE;
                    end
                endcase
            end
            MODE_MEM: begin
                legal_s          = 1'b1;
                ctrl_s.exe_cmd   = CMD_ADD;
                ctrl_s.mem_read  = if_instr[20];
                ctrl_s.wb_en     = if_instr[20];
                ctrl_s.mem_write = ~if_instr[20];
                use_src2_s       = ~if_instr[20];
            end
            MODE_BR: begin
                legal_s        = 1'b1;
                ctrl_s.b       = 1'b1;
                ctrl_s.exe_cmd = CMD_NONE;
                use_src1_s     = 1'b0;
            end
            default: begin
                legal_s = 1'b0;
            end
        endcase
        ctrl_s.valid = legal_s;
    end

`ifdef ID_FORWARDING_EN
    // Only a load in EX cannot be forwarded in time; MEM results are forwarded
    assign reg_hz_s = ex_wb_en & ex_mem_read &
                      ((use_src1_s & (ex_dest == src1_s)) |
                       (use_src2_s & (ex_dest == src2_s)));
    assign unused_fwd_s = mem_wb_en ^ (^mem_dest);
`else
    // Without forwarding any pending EX or MEM write to a used source stalls
    assign reg_hz_s = (ex_wb_en  & ((use_src1_s & (ex_dest  == src1_s)) |
                                    (use_src2_s & (ex_dest  == src2_s)))) |
                      (mem_wb_en & ((use_src1_s & (mem_dest == src1_s)) |
                                    (use_src2_s & (mem_dest == src2_s))));
    assign unused_fwd_s = ex_mem_read;
`endif

    // Flags written by the EX instruction are not yet visible to a conditional
    assign stat_hz_s = (if_instr[31:28] != COND_AL) & ex_s_en;
    assign hazard_s  = if_valid & (reg_hz_s | stat_hz_s);
    assign stall     = hazard_s & ~flush;
    assign issue_s   = if_valid & ~flush & ~hazard_s & cond_ok_s & legal_s;

    // ID/EX register: reset clears everything, otherwise issue or insert a bubble
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_r     <= ID_CTRL_BUBBLE;
            pc_r       <= {DATA_W{1'b0}};
            val_rn_r   <= {DATA_W{1'b0}};
            val_rm_r   <= {DATA_W{1'b0}};
            shift_op_r <= 12'h000;
            simm24_r   <= 24'h000000;
            dest_r     <= {REG_AW{1'b0}};
            src1_r     <= {REG_AW{1'b0}};
            src2_r     <= {REG_AW{1'b0}};
        end else begin
            pc_r       <= if_pc;
            val_rn_r   <= rf_val1;
            val_rm_r   <= rf_val2;
            shift_op_r <= if_instr[11:0];
            simm24_r   <= if_instr[23:0];
            dest_r     <= dest_s;
            src1_r     <= src1_s;
            src2_r     <= src2_s;
            if (issue_s) begin
                ctrl_r <= ctrl_s;
            end else begin
                ctrl_r <= ID_CTRL_BUBBLE;
            end
        end
    end

    assign id_valid     = ctrl_r.valid;
    assign id_wb_en     = ctrl_r.wb_en;
    assign id_mem_read  = ctrl_r.mem_read;
    assign id_mem_write = ctrl_r.mem_write;
    assign id_b         = ctrl_r.b;
    assign id_s         = ctrl_r.s;
    assign id_imm       = ctrl_r.imm;
    assign id_exe_cmd   = ctrl_r.exe_cmd;
    assign id_pc        = pc_r;
    assign id_val_rn    = val_rn_r;
    assign id_val_rm    = val_rm_r;
    assign id_shift_op  = shift_op_r;
    assign id_simm24    = simm24_r;
    assign id_dest      = dest_r;
    assign id_src1      = src1_r;
    assign id_src2      = src2_r;

endmodule
